wrr_grant_scheduler: RTL and testbench
======================================

# wrr_grant_scheduler

Weighted round-robin scheduler that shares one single-beat resource port among N requesters. It grants one requester at a time, holds the grant for up to a per-requester beat quota, and inserts a one-cycle turnaround gap before re-arbitrating. It extends the team's fixed-quota 4-way round-robin arbitration with programmable weights, an accept-driven beat count, and a registered grant ID for datapath mux steering.

## Interface
- N, default 4: number of requesters, 2..8
- WEIGHT_W, default 3: width of each per-requester quota field
- ID_W, default $clog2(N): width of grant_id

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req  in  N  per-requester request level; bit i = requester i
- cfg_weight  in  N*WEIGHT_W  beat quota per requester; field i = bits [i*WEIGHT_W +: WEIGHT_W]; quasi-static
- beat_acc  in  1  resource accepted one beat from the current grantee this cycle
- grant  out  N  one-hot registered grant; all-zero when no grant
- grant_id  out  ID_W  index of current grantee; holds its last value when grant==0
- busy  out  1  high in GRANT and GAP states

## Operation
- States:
  - IDLE: no grant, not busy
  - GRANT: exactly one grant bit set
  - GAP: one turnaround cycle, grant==0, busy=1
- IDLE → GRANT when any req bit is high. Winner = first set req bit scanning from ptr upward, modulo N.
- In GRANT with grantee g:
  - On each cycle with beat_acc=1, beat_cnt increments.
  - Leave for GAP when req[g]==0, or when beat_acc=1 and beat_cnt+1 == eff_weight(g).
  - Otherwise stay in GRANT.
- On leaving GRANT: ptr ← (g+1) mod N and beat_cnt ← 0.
- GAP → GRANT next cycle if any req bit is high, using the updated ptr. Otherwise GAP → IDLE.
- eff_weight(i) = cfg_weight field i, except a field value of 0 is treated as 1. The weight is latched at grant time, so cfg changes mid-grant do not affect the current grant.
- beat_acc is ignored outside GRANT.
- A grantee that keeps req high and uses its full quota still loses the grant. It re-wins only after all other active requesters have been served once; if it is the only requester, it re-wins after the GAP cycle.
- req bits of non-grantees are not latched; a requester dropping req before it wins is simply skipped.
- Simultaneous req[g] fall and beat_acc=1: the beat counts, then the grant is released (single exit to GAP).
- Reset:
  - grant=0, grant_id=0, busy=0
  - state=IDLE, ptr=0, beat_cnt=0
- Reset asserted mid-grant clears everything in the next cycle regardless of beat_acc.

## Timing
- All outputs are registered; there is no combinational path from req or beat_acc to outputs.
- req rises at cycle t in IDLE → grant/grant_id valid at t+1.
- Final quota beat accepted at cycle t → grant==0 at t+1 (GAP) → next grant at t+2.
- req[g] low at cycle t → grant==0 at t+1.
- Minimum grant length is 1 cycle. Maximum number of beats per grant is 2^WEIGHT_W−1.
- beat_cnt is WEIGHT_W bits wide and never exceeds eff_weight−1.
- ptr is ID_W bits wide and wraps from N−1 to 0.

## Structure
- Shared package wrr_pkg holds:
  - state enum {IDLE, GRANT, GAP}
  - default N and WEIGHT_W constants
  - a function returning eff_weight (0→1)
- Sub-module rr_pick: combinational rotating priority encoder.
  - Inputs: req[N], ptr[ID_W]
  - Outputs: any, win_id[ID_W], win_onehot[N]
- The top level holds the FSM, beat counter, latched weight, ptr, and output registers.

## Test plan
- Reset, then req=0001, weight0=3, beat_acc held 1:
  - grant=0001 at cycle 1
  - GAP at cycle 4
  - grant=0001 again at cycle 5
  - exactly 3 accepted beats per grant
- req=1111, all weights=2, beat_acc=1 → grant order 0,1,2,3,0, each held 2 cycles with a 1-cycle gap between grants.
- Weights {1,3,0,2}, req=1111, beat_acc=1:
  - hold lengths are 1,3,1,2
  - weight 0 behaves as 1
- Grantee 2 drops req after 1 beat with weight 4 → GAP the next cycle, then grant goes to 3 (ptr=3), not 2.
- beat_acc=0 for 5 cycles with req[g] high → grant held, beat_cnt stays 0; a later beat counts normally.
- rst pulsed mid-grant on requester 1 → grant=0, busy=0, grant_id=0 the next cycle. After release, the first grant goes to the lowest active index from 0.

Source files
------------

// File: rtl/wrr_pkg.sv
// wrr_pkg: shared state encoding, default sizes and quota helper for the WRR scheduler
package wrr_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  localparam int DEF_N = 4;
  localparam int DEF_WEIGHT_W = 3;
  function automatic int eff_weight(input int w);
    return (w == 0) ? 1 : w;
  endfunction
endpackage

// File: rtl/wrr_grant_scheduler_rr_pick.sv
// rr_pick: rotating priority encoder, first set req bit at or above ptr modulo N
module rr_pick #(
  parameter int N = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic            any,
  output logic [ID_W-1:0] win_id,
  output logic [N-1:0]    win_onehot
);
  always_comb begin
    any = |req;
    win_id = '0;
    // scan downward so the candidate closest to ptr is written last
    for (int k = N - 1; k >= 0; k--)
      win_id = req[(int'(ptr) + k) % N] ? ID_W'((int'(ptr) + k) % N) : win_id;
    win_onehot = any ? (N'(1) << win_id) : '0;
  end
endmodule

// File: rtl/wrr_grant_scheduler.sv
// wrr_grant_scheduler: weighted round-robin grant of a single-beat port with one-cycle turnaround
module wrr_grant_scheduler
  import wrr_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int ID_W = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [N*WEIGHT_W-1:0] cfg_weight,
  input  logic                  beat_acc,
  output logic [N-1:0]          grant,
  output logic [ID_W-1:0]       grant_id,
  output logic                  busy
);
  state_t state;
  logic any, done;
  logic [ID_W-1:0] win_id, ptr;
  logic [N-1:0] win_onehot;
  logic [WEIGHT_W-1:0] beat_cnt, wt;

  rr_pick #(.N(N), .ID_W(ID_W)) u_pick (
    .req(req),
    .ptr(ptr),
    .any(any),
    .win_id(win_id),
    .win_onehot(win_onehot)
  );

  assign done = !req[grant_id] || (beat_acc && (beat_cnt + 1'b1) == wt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      beat_cnt <= '0;
      wt <= '0;
      grant <= '0;
      grant_id <= '0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE, GAP: begin
          state <= any ? GRANT : IDLE;
          grant <= win_onehot;
          busy <= any;
          beat_cnt <= '0;
          if (any) begin
            grant_id <= win_id;
            wt <= WEIGHT_W'(eff_weight(int'(cfg_weight[int'(win_id)*WEIGHT_W +: WEIGHT_W])));
          end
        end
        GRANT: begin
          if (done) begin
            state <= GAP;
            grant <= '0;
            beat_cnt <= '0;
            ptr <= (grant_id == ID_W'(N - 1)) ? '0 : grant_id + 1'b1;
          end else
            beat_cnt <= beat_cnt + WEIGHT_W'(beat_acc);
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wrr_grant_scheduler.sv
// tb_wrr_grant_scheduler: directed vectors with hand-computed grant sequences
module tb_wrr_grant_scheduler;
  logic clk = 0, rst = 1, beat_acc = 0;
  logic [3:0] req = '0, grant;
  logic [11:0] cfg_weight = '0;
  logic [1:0] grant_id;
  logic busy;
  int total = 0, bad = 0, n;

  logic [3:0] e1 [5]  = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
  logic [3:0] e2 [13] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0100,
                          4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
  logic [3:0] e3 [12] = '{4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0100,
                          4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};

  always #5 clk = ~clk;

  wrr_grant_scheduler #(.N(4), .WEIGHT_W(3), .ID_W(2)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .cfg_weight(cfg_weight),
    .beat_acc(beat_acc),
    .grant(grant),
    .grant_id(grant_id),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    req = '0;
    beat_acc = 0;
    tick();
  endtask

  initial begin
    do_reset();
    tick();
    chk("rst_grant", grant, 0);
    chk("rst_id", grant_id, 0);
    chk("rst_busy", busy, 0);

    // single requester, quota 3, re-wins after the gap
    cfg_weight = {3'd1, 3'd1, 3'd1, 3'd3};
    req = 4'b0001;
    beat_acc = 1;
    rst = 0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t1_grant_c%0d", i + 1), grant, e1[i]);
      chk($sformatf("t1_busy_c%0d", i + 1), busy, 1);
      if (i < 3 && grant == 4'b0001) n++;
    end
    chk("t1_beats", n, 3);
    req = '0;
    tick();
    chk("t1_gap_grant", grant, 0);
    chk("t1_gap_busy", busy, 1);
    tick();
    chk("t1_idle_busy", busy, 0);

    // all requesting, weight 2 each
    do_reset();
    cfg_weight = {3'd2, 3'd2, 3'd2, 3'd2};
    req = 4'b1111;
    beat_acc = 1;
    rst = 0;
    for (int i = 0; i < 13; i++) begin
      tick();
      chk($sformatf("t2_grant_c%0d", i + 1), grant, e2[i]);
      if (i == 9) chk("t2_id3", grant_id, 3);
    end

    // weights {1,3,0,2}; zero behaves as one
    do_reset();
    cfg_weight = {3'd2, 3'd0, 3'd3, 3'd1};
    req = 4'b1111;
    beat_acc = 1;
    rst = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("t3_grant_c%0d", i + 1), grant, e3[i]);
    end

    // grantee 2 drops req after one beat; ptr moves to 3
    do_reset();
    cfg_weight = {3'd1, 3'd4, 3'd1, 3'd1};
    req = 4'b0100;
    beat_acc = 1;
    rst = 0;
    tick();
    chk("t4_grant2", grant, 4'b0100);
    chk("t4_id2", grant_id, 2);
    tick();
    chk("t4_hold2", grant, 4'b0100);
    req = 4'b1000;
    tick();
    chk("t4_gap_grant", grant, 0);
    chk("t4_gap_busy", busy, 1);
    req = 4'b1101;
    tick();
    chk("t4_grant3", grant, 4'b1000);
    chk("t4_id3", grant_id, 3);

    // no accepts for 5 cycles keeps grant and beat count at zero
    do_reset();
    cfg_weight = {3'd1, 3'd1, 3'd2, 3'd1};
    req = 4'b0010;
    beat_acc = 0;
    rst = 0;
    tick();
    chk("t5_grant", grant, 4'b0010);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t5_stall_c%0d", i + 2), grant, 4'b0010);
    end
    beat_acc = 1;
    tick();
    chk("t5_first_beat", grant, 4'b0010);
    tick();
    chk("t5_quota_gap", grant, 0);
    tick();
    chk("t5_rewin", grant, 4'b0010);

    // reset mid-grant on requester 1 also clears ptr
    do_reset();
    cfg_weight = {3'd1, 3'd1, 3'd5, 3'd1};
    req = 4'b0011;
    beat_acc = 1;
    rst = 0;
    tick();
    chk("t6_grant0", grant, 4'b0001);
    tick();
    chk("t6_gap", grant, 0);
    tick();
    chk("t6_grant1", grant, 4'b0010);
    tick();
    chk("t6_hold1", grant, 4'b0010);
    rst = 1;
    tick();
    chk("t6_rst_grant", grant, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_id", grant_id, 0);
    rst = 0;
    req = 4'b1001;
    tick();
    chk("t6_after_grant", grant, 4'b0001);
    chk("t6_after_id", grant_id, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
